calc_sequencer: RTL and testbench
=================================

// Module: calc_sequencer
// PURPOSE
//  Sequences the 16-bit signed calculator. Consumes decoded keypad events from input_control over the
//  KeyRdy/KeyRd handshake, builds operands A and B in decimal, and issues operations to the ALU over a
//  start/done handshake. Holds the result for display and chains it into the next operation.
// PARAMETERS
//  DATA_W       16   operand/result width, two's complement; digit-entry max is 2^(DATA_W-1)-1
//  ALU_TIMEOUT  255  cycles to wait for alu_done before error (CALC_TIMEOUT_EN only)
// PORTS
//  clk             in   1       system clock, all logic on posedge
//  RST             in   1       synchronous, active-high reset
//  KeyRdy          in   1       input_control has a key event pending
//  KeyRd           out  1       one-cycle ack: key consumed
//  keypad_input    in   4       digit 0-9; values >9 ignored
//  operator_input  in   3       000 none, 001 ADD, 010 SUB, 011 MUL, 100 DIV, 111 CLEAR; others ignored
//  equal_input     in   1       '=' key
//  alu_start       out  1       one-cycle pulse to launch an operation
//  alu_op          out  3       operator code, same encoding as operator_input
//  alu_a, alu_b    out  DATA_W  operands; stable from alu_start until alu_done
//  alu_done        in   1       ALU result valid; sampled from the cycle after alu_start
//  alu_result      in   DATA_W  ALU result
//  alu_ovf         in   1       ALU overflow, qualified by alu_done
//  display_value   out  DATA_W  operand being entered, or the last result
//  error           out  1       sticky error flag
// BEHAVIOUR
//  Reset: state=ENTER_A; A=B=0; pending op=000; KeyRd=0; alu_start=0; alu_op=0; alu_a=alu_b=0;
//   display_value=0; error=0; watchdog=0. Reset mid-EXEC abandons the ALU op; a late alu_done is ignored.
//  Key intake: when KeyRdy=1, KeyRd=0 and state!=EXEC, latch the key fields and set KeyRd=1 next cycle
//   for exactly 1 cycle. Key decode priority: equal > operator (!=000) > digit. No second key is sampled
//   while KeyRd=1. In EXEC, KeyRdy is held off (no KeyRd) until EXEC exits.
//  Digit entry: opnd <= opnd*10+digit, computed at DATA_W+4 bits. If result > 2^(DATA_W-1)-1, the
//   digit is discarded (opnd unchanged). display_value tracks the operand being entered.
//  FSM states: ENTER_A, OP_WAIT, ENTER_B, EXEC, RESULT, ERROR.
//   ENTER_A : digit->update A; op->latch op, OP_WAIT; '='->no-op.
//   OP_WAIT : op->replace pending op; digit->B=digit, ENTER_B; '='->ignored.
//   ENTER_B : digit->update B; '='->EXEC (then RESULT); op->EXEC, then A=result, op latched, OP_WAIT.
//   EXEC    : on entry, DIV with B=0 -> ERROR with no alu_start. Otherwise alu_start pulses 1 cycle.
//             On alu_done: alu_ovf=1 -> ERROR; else display_value=A=alu_result.
//   RESULT  : digit->A=digit, ENTER_A; op->A kept, OP_WAIT; '='->ignored.
//   ERROR   : error=1, display_value=0; every key except CLEAR is acked and ignored.
//  CLEAR (111) in any state except EXEC returns to the reset values; error is cleared the cycle after KeyRd.
//  alu_done arriving in the same cycle as alu_start is ignored.
// CONFIGURATION
//  CALC_TIMEOUT_EN defined: an 8+ bit watchdog counts EXEC cycles after alu_start. Reaching
//   ALU_TIMEOUT -> ERROR, and a later alu_done is ignored. Not defined: EXEC waits for alu_done indefinitely.
// TESTING
//  1 Reset: RST=1 for 2 cycles -> display_value=0, error=0, KeyRd=0, alu_start=0.
//  2 Keys 1,2,+,3,= with ALU model (a+b, done 3 cycles later) -> one alu_start, alu_op=001, alu_a=12,
//    alu_b=3, display_value=15, one 1-cycle KeyRd per key.
//  3 Keys 3,2,7,6,7,1 -> display_value=32767 (final digit discarded, still acked).
//  4 Keys 5,/,0,= -> no alu_start, error=1, display_value=0; CLEAR -> error=0, display_value=0.
//  5 Keys 6,*,7,-,2,= -> two alu_start pulses (6*7, then 42-2), display_value=40. Key held during EXEC
//    is not acked until EXEC exits.
//  6 CALC_TIMEOUT_EN, ALU_TIMEOUT=16, alu_done never asserted -> error=1 after 16 cycles.
//    Macro off -> stays in EXEC, error=0.

Source files
------------

// File: rtl/calc_sequencer.sv
// Calculator sequencer: keypad handshake intake, decimal operand entry, ALU start/done sequencing.
// Optional EXEC watchdog enabled by defining CALC_TIMEOUT_EN.
module calc_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              KeyRdy,
  output logic              KeyRd,
  input  logic [3:0]        keypad_input,
  input  logic [2:0]        operator_input,
  input  logic              equal_input,
  output logic              alu_start,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf,
  output logic [DATA_W-1:0] display_value,
  output logic              error
);

  typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, EXEC, RESULT, ERROR} state_t;

  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_CLEAR = 3'b111;
  localparam int EW   = DATA_W + 4;
  localparam int WD_W = ($clog2(ALU_TIMEOUT + 1) > 8) ? $clog2(ALU_TIMEOUT + 1) : 8;
  localparam logic [EW-1:0] OPND_MAX = {5'b0, {(DATA_W-1){1'b1}}};

  state_t            state_q, state_n;
  logic [DATA_W-1:0] a_q, a_n, b_q, b_n;
  logic [2:0]        op_q, op_n, chain_op_q, chain_op_n;
  logic              chain_q, chain_n, launched_q, launched_n;
  logic              key_rd_q, key_eq_q;
  logic [2:0]        key_op_q;
  logic [3:0]        key_dig_q;
  logic              alu_start_q, alu_start_n;
  logic [2:0]        alu_op_q, alu_op_n;
  logic [DATA_W-1:0] alu_a_q, alu_a_n, alu_b_q, alu_b_n;
  logic [DATA_W-1:0] disp_q, disp_n;
  logic              err_q, err_n, to_err;
  logic [WD_W-1:0]   wdog_q, wdog_n;

  logic              is_clear, is_op, is_dig, is_eq, fits;
  logic [EW-1:0]     entry;

  assign is_eq    = key_rd_q && key_eq_q;
  assign is_clear = key_rd_q && !key_eq_q && (key_op_q == OP_CLEAR);
  assign is_op    = key_rd_q && !key_eq_q && (key_op_q inside {3'b001, 3'b010, 3'b011, 3'b100});
  assign is_dig   = key_rd_q && !key_eq_q && (key_op_q == 3'b000) && (key_dig_q <= 4'd9);

  // Digit append on whichever operand is being typed; wide enough that overflow can be detected.
  assign entry = {4'b0, (state_q == ENTER_B) ? b_q : a_q} * EW'(10) + EW'(key_dig_q);
  assign fits  = (entry <= OPND_MAX);

  always_comb begin
    state_n     = state_q;
    a_n         = a_q;
    b_n         = b_q;
    op_n        = op_q;
    chain_n     = chain_q;
    chain_op_n  = chain_op_q;
    launched_n  = launched_q;
    alu_start_n = 1'b0;
    alu_op_n    = alu_op_q;
    alu_a_n     = alu_a_q;
    alu_b_n     = alu_b_q;
    disp_n      = disp_q;
    err_n       = err_q;
    wdog_n      = wdog_q;
    to_err      = 1'b0;
    if (is_clear && state_q != EXEC) begin
      state_n    = ENTER_A;
      a_n        = '0;
      b_n        = '0;
      op_n       = '0;
      chain_n    = 1'b0;
      chain_op_n = '0;
      launched_n = 1'b0;
      alu_op_n   = '0;
      alu_a_n    = '0;
      alu_b_n    = '0;
      disp_n     = '0;
      err_n      = 1'b0;
      wdog_n     = '0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (is_op) begin
            op_n    = key_op_q;
            state_n = OP_WAIT;
          end else if (is_dig && fits) begin
            a_n    = entry[DATA_W-1:0];
            disp_n = entry[DATA_W-1:0];
          end
        end
        OP_WAIT: begin
          if (is_op) begin
            op_n = key_op_q;
          end else if (is_dig) begin
            b_n     = DATA_W'(key_dig_q);
            disp_n  = DATA_W'(key_dig_q);
            state_n = ENTER_B;
          end
        end
        ENTER_B: begin
          if (is_eq || is_op) begin
            chain_n    = is_op;
            chain_op_n = key_op_q;
            launched_n = 1'b0;
            wdog_n     = '0;
            state_n    = EXEC;
          end else if (is_dig && fits) begin
            b_n    = entry[DATA_W-1:0];
            disp_n = entry[DATA_W-1:0];
          end
        end
        EXEC: begin
          if (!launched_q) begin
            if (op_q == OP_DIV && b_q == '0) begin
              to_err = 1'b1;
            end else begin
              alu_start_n = 1'b1;
              alu_op_n    = op_q;
              alu_a_n     = a_q;
              alu_b_n     = b_q;
              launched_n  = 1'b1;
            end
          end else if (!alu_start_q) begin
            // alu_done coincident with the start pulse is not a completion
            if (alu_done) begin
              if (alu_ovf) begin
                to_err = 1'b1;
              end else begin
                a_n        = alu_result;
                disp_n     = alu_result;
                launched_n = 1'b0;
                chain_n    = 1'b0;
                if (chain_q) begin
                  op_n    = chain_op_q;
                  state_n = OP_WAIT;
                end else begin
                  state_n = RESULT;
                end
              end
            end else begin
              if (wdog_q != WD_W'(ALU_TIMEOUT)) wdog_n = wdog_q + 1'b1;
`ifdef CALC_TIMEOUT_EN
              if (wdog_q + 1'b1 == WD_W'(ALU_TIMEOUT)) to_err = 1'b1;
`endif
            end
          end
        end
        RESULT: begin
          if (is_op) begin
            op_n    = key_op_q;
            state_n = OP_WAIT;
          end else if (is_dig) begin
            a_n     = DATA_W'(key_dig_q);
            disp_n  = DATA_W'(key_dig_q);
            state_n = ENTER_A;
          end
        end
        default: ;
      endcase
    end
    if (to_err) begin
      state_n    = ERROR;
      err_n      = 1'b1;
      disp_n     = '0;
      launched_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= ENTER_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      chain_q     <= 1'b0;
      chain_op_q  <= '0;
      launched_q  <= 1'b0;
      key_rd_q    <= 1'b0;
      key_eq_q    <= 1'b0;
      key_op_q    <= '0;
      key_dig_q   <= '0;
      alu_start_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      disp_q      <= '0;
      err_q       <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_n;
      a_q         <= a_n;
      b_q         <= b_n;
      op_q        <= op_n;
      chain_q     <= chain_n;
      chain_op_q  <= chain_op_n;
      launched_q  <= launched_n;
      alu_start_q <= alu_start_n;
      alu_op_q    <= alu_op_n;
      alu_a_q     <= alu_a_n;
      alu_b_q     <= alu_b_n;
      disp_q      <= disp_n;
      err_q       <= err_n;
      wdog_q      <= wdog_n;
      key_rd_q    <= KeyRdy && !key_rd_q && (state_q != EXEC);
      if (KeyRdy && !key_rd_q && (state_q != EXEC)) begin
        key_eq_q  <= equal_input;
        key_op_q  <= operator_input;
        key_dig_q <= keypad_input;
      end
    end
  end

  assign KeyRd         = key_rd_q;
  assign alu_start     = alu_start_q;
  assign alu_op        = alu_op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign display_value = disp_q;
  assign error         = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: expected ALU launches are queued by the stimulus and
// checked by a monitor on alu_start; a behavioural ALU answers 3 cycles after each start.
module tb_calc_sequencer;
  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        KeyRdy = 1'b0;
  logic        KeyRd;
  logic [3:0]  keypad_input = '0;
  logic [2:0]  operator_input = '0;
  logic        equal_input = 1'b0;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        alu_ovf = 1'b0;
  logic [15:0] display_value;
  logic        error;

  calc_sequencer #(.DATA_W(16), .ALU_TIMEOUT(16)) dut (
    .clk(clk), .RST(RST), .KeyRdy(KeyRdy), .KeyRd(KeyRd),
    .keypad_input(keypad_input), .operator_input(operator_input), .equal_input(equal_input),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .display_value(display_value), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] op; logic [15:0] a; logic [15:0] b; } launch_t;
  launch_t     exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned ack_cyc = 0;
  int unsigned done_cyc = 0;
  logic        alu_en = 1'b1;
  logic        start_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every alu_start must match the oldest queued launch and last one cycle.
  always @(negedge clk) begin
    if (alu_start) begin
      checks++;
      if (start_prev) begin
        errors++;
        $display("FAIL alu_start_width: got 2+ cycles expected 1");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_launch: got op=%0d a=%0d b=%0d expected none", alu_op, alu_a, alu_b);
      end else begin
        launch_t e;
        e = exp_q.pop_front();
        if ({alu_op, alu_a, alu_b} !== e) begin
          errors++;
          $display("FAIL launch: got op=%0d a=%0d b=%0d expected op=%0d a=%0d b=%0d",
                   alu_op, alu_a, alu_b, e.op, e.a, e.b);
        end
      end
    end
    start_prev <= alu_start;
  end

  // Behavioural ALU, answers 3 cycles after the start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (alu_start && alu_en) begin
        logic signed [15:0] a, b, r;
        a = alu_a; b = alu_b;
        case (alu_op)
          3'b001:  r = a + b;
          3'b010:  r = a - b;
          3'b011:  r = a * b;
          3'b100:  r = (b != 0) ? a / b : 16'sd0;
          default: r = 16'sd0;
        endcase
        repeat (2) @(negedge clk);
        alu_result = r;
        alu_done   = 1'b1;
        done_cyc   = cyc;
        @(negedge clk);
        alu_done   = 1'b0;
      end
    end
  end

  task automatic press(input logic [3:0] d, input logic [2:0] o, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    keypad_input = d; operator_input = o; equal_input = e; KeyRdy = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!KeyRd && n < 200);
    KeyRdy = 1'b0;
    check("key_ack", KeyRd, 1);
    ack_cyc = cyc;
    @(negedge clk);
    check("keyrd_pulse", KeyRd, 0);
  endtask

  task automatic digit(input logic [3:0] d); press(d, 3'b000, 1'b0); endtask
  task automatic oper(input logic [2:0] o);  press(4'd0, o, 1'b0);   endtask
  task automatic equals();                  press(4'd0, 3'b000, 1'b1); endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    check("rst_display", display_value, 0);
    check("rst_error", error, 0);
    check("rst_keyrd", KeyRd, 0);
    check("rst_start", alu_start, 0);

    // 12 + 3 =
    digit(1); digit(2);
    check("entry_12", display_value, 12);
    oper(3'b001); digit(3);
    check("entry_b3", display_value, 3);
    exp_q.push_back('{3'b001, 16'd12, 16'd3});
    equals();
    repeat (10) @(negedge clk);
    check("add_result", display_value, 15);
    check("add_queue_empty", exp_q.size(), 0);
    oper(3'b111);
    check("clear_disp", display_value, 0);

    // Max-value entry, last digit dropped but acked
    digit(3); digit(2); digit(7); digit(6); digit(7);
    check("entry_max", display_value, 32767);
    digit(1);
    check("entry_overflow_discard", display_value, 32767);
    digit(4'd12);
    check("digit_gt9_ignored", display_value, 32767);
    oper(3'b111);

    // Divide by zero
    digit(5); oper(3'b100); digit(0); equals();
    repeat (4) @(negedge clk);
    check("div0_error", error, 1);
    check("div0_display", display_value, 0);
    digit(7);
    check("error_ignores_digit", display_value, 0);
    oper(3'b111);
    check("clear_error", error, 0);
    check("clear_display", display_value, 0);

    // Chained 6*7-2 with a key held during EXEC
    digit(6); oper(3'b011); digit(7);
    exp_q.push_back('{3'b011, 16'd6, 16'd7});
    oper(3'b010);
    digit(2);
    check("key_held_off_in_exec", (ack_cyc > done_cyc) ? 1 : 0, 1);
    check("chain_b_display", display_value, 2);
    exp_q.push_back('{3'b010, 16'd42, 16'd2});
    equals();
    repeat (10) @(negedge clk);
    check("chain_result", display_value, 40);
    check("chain_queue_empty", exp_q.size(), 0);
    oper(3'b111);

    // Silent ALU: watchdog
    alu_en = 1'b0;
    digit(1); oper(3'b001); digit(2);
    exp_q.push_back('{3'b001, 16'd1, 16'd2});
    equals();
`ifdef CALC_TIMEOUT_EN
    repeat (25) @(negedge clk);
    check("timeout_error", error, 1);
    check("timeout_display", display_value, 0);
`else
    repeat (40) @(negedge clk);
    check("no_timeout_error", error, 0);
    @(negedge clk);
    keypad_input = 4'd9; operator_input = 3'b000; equal_input = 1'b0; KeyRdy = 1'b1;
    repeat (20) @(negedge clk);
    check("exec_blocks_key", KeyRd, 0);
    KeyRdy = 1'b0;
`endif
    // Reset mid-operation, then normal entry
    @(negedge clk);
    RST = 1'b1;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    alu_en = 1'b1;
    @(negedge clk);
    check("reset_exec_display", display_value, 0);
    check("reset_exec_error", error, 0);
    digit(9);
    check("post_reset_entry", display_value, 9);
    check("launch_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
